fp_normalize_pipe: RTL
======================

# fp_normalize_pipe

Two-stage pipelined, parametrised mantissa normaliser for the floating-point multiplier datapath. Between the mantissa multiplier and the rounder it either left-normalises a WIDTH-bit product using a leading-zero count, or right-shifts by a requested amount for denormal alignment. It adjusts the exponent to match and reports zero, sticky and exponent-range flags. A valid/ready handshake with full backpressure moves one operation per cycle.

## Interface
- WIDTH, 48: mantissa/product width in bits (≥ 8).
- EXP_W, 10: signed exponent width in bits.
- CNT_W, $clog2(WIDTH+1): shift-count width.

- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream operation valid.
- o_ready  output  1  block can accept an operation this cycle.
- i_data  input  WIDTH  unnormalised mantissa.
- i_exp  input  EXP_W  signed exponent before normalisation.
- i_left  input  1  1 = left-normalise by leading-zero count; 0 = right-shift by i_amt.
- i_amt  input  CNT_W  right-shift amount; ignored when i_left=1.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_data  output  WIDTH  shifted mantissa.
- o_exp  output  EXP_W  adjusted exponent.
- o_count  output  CNT_W  shift amount actually applied.
- o_zero  output  1  i_data was all zeros.
- o_sticky  output  1  OR of the bits shifted out on a right shift.
- o_exp_ovf  output  1  the adjusted exponent does not fit in signed EXP_W.

## Operation
- Stage A, on accept:
  - Registers i_data, i_exp and i_left.
  - Registers the shift count: the leading-zero count of i_data (0..WIDTH) when i_left=1, or i_amt when i_left=0.
- Stage B, on advance from A: performs the shift and exponent adjustment and registers every o_* signal.
- Left mode (i_left=1):
  - o_data = data << count, so MSB = 1 for nonzero input.
  - o_exp = i_exp − count.
  - o_sticky = 0.
- Right mode (i_left=0):
  - o_data = data >> count, zero-filled.
  - o_exp = i_exp + count.
  - o_sticky = OR of the count LSBs that were discarded.
- Zero input:
  - In left mode: count = WIDTH, o_data = 0, o_exp = i_exp (no adjustment), o_zero = 1.
  - In right mode: o_zero = 1 and the shift proceeds normally.
- Right shift with count ≥ WIDTH: o_data = 0 and o_sticky = OR of all of data.
- Exponent arithmetic is done in EXP_W+1 bits:
  - o_exp_ovf = 1 when the result is outside [−2^(EXP_W−1), 2^(EXP_W−1)−1].
  - o_exp is the low EXP_W bits of the result.
- o_count always reports the applied shift (the clamped value in the zero left-mode case).

## Timing
- Latency: 2 cycles from an accepted input (i_valid & o_ready) to o_valid.
- Throughput: 1 operation per cycle when i_ready is held high.
- Pipeline rules:
  - advB = !vB | i_ready.
  - advA = !vA | advB.
  - o_ready = advA, combinational.
  - o_valid = vB.
- While o_valid=1 and i_ready=0, all o_* signals hold stable and no operation is lost.
- Simultaneous accept and drain in one cycle: both stages shift together and no bubble is inserted.
- Reset (asynchronous, any time, including mid-operation):
  - vA and vB clear, so o_valid = 0 and in-flight operations are discarded.
  - All o_* data and flag outputs read 0.
  - o_ready = 1 once reset is deasserted.
- Inputs are sampled only on accept; i_data may change freely while o_ready = 0.

## Configuration
- NORM_STICKY_EN:
  - Defined: the sticky reduction logic is built and o_sticky behaves as specified above.
  - Undefined: o_sticky is tied to 0, the discarded-bit OR logic is removed, and right shifts simply truncate. All other behaviour is identical.

## Test plan
- Left normalise, WIDTH=48: i_data = 48'h0000_0000_0001, i_exp = 10 -> 2 cycles later o_data = 48'h8000_0000_0000, o_count = 47, o_exp = −37, o_exp_ovf = 0.
- Zero input: i_data = 0, i_left = 1, i_exp = 5 -> o_zero = 1, o_count = 48, o_data = 0, o_exp = 5.
- Right shift with sticky (NORM_STICKY_EN defined): i_data = 48'h8000_0000_0003, i_amt = 2, i_exp = −3 -> o_data = 48'h2000_0000_0000, o_sticky = 1, o_exp = −1. With the macro undefined: o_sticky = 0.
- Exponent overflow: i_exp = −510, i_data = 48'h0000_0000_00FF, left mode -> o_count = 40, o_exp_ovf = 1.
- Backpressure: stream 5 back-to-back operations while i_ready toggles 1,0,0,1,… -> all 5 results delivered in order, outputs stable while stalled, o_ready = 0 only when both stages are full and i_ready = 0.
- Reset mid-operation: assert i_rst_n = 0 with both stages valid -> o_valid = 0 and all outputs 0 immediately, without waiting for a clock edge. After release, the first new operation appears 2 cycles after its accept.

Source files
------------

// File: rtl/fp_normalize_pipe.sv
// Two-stage mantissa normaliser: left-normalise by leading-zero count or right-shift for alignment.
// Define NORM_STICKY_EN to build the discarded-bit sticky reduction; otherwise o_sticky is tied to 0.
module fp_normalize_pipe #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned EXP_W = 10,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [EXP_W-1:0] i_exp,
  input  logic             i_left,
  input  logic [CNT_W-1:0] i_amt,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [EXP_W-1:0] o_exp,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero,
  output logic             o_sticky,
  output logic             o_exp_ovf
);

  localparam int unsigned XW = EXP_W + 1;

  logic             va_q, vb_q;
  logic             adv_a, adv_b;
  logic [WIDTH-1:0] data_a_q;
  logic [EXP_W-1:0] exp_a_q;
  logic             left_a_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_a_d;

  logic [WIDTH-1:0] data_b_d, data_b_q;
  logic [EXP_W-1:0] exp_b_q;
  logic [CNT_W-1:0] cnt_b_q;
  logic             zero_b_d, zero_b_q;
  logic             sticky_b_d, sticky_b_q;
  logic             ovf_b_d, ovf_b_q;
  logic [XW-1:0]    exp_ext, cnt_ext, exp_x;

  assign adv_b   = !vb_q || i_ready;
  assign adv_a   = !va_q || adv_b;
  assign o_ready = adv_a;
  assign o_valid = vb_q;

  // Leading-zero count, WIDTH for an all-zero operand.
  function automatic logic [CNT_W-1:0] lzc(input logic [WIDTH-1:0] d);
    logic [CNT_W-1:0] n;
    logic             found;
    n     = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        n     = CNT_W'(int'(WIDTH) - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  assign cnt_a_d = i_left ? lzc(i_data) : i_amt;

  // Stage A: capture operands and the shift count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      va_q     <= 1'b0;
      data_a_q <= '0;
      exp_a_q  <= '0;
      left_a_q <= 1'b0;
      cnt_a_q  <= '0;
    end else if (adv_a) begin
      va_q <= i_valid;
      if (i_valid) begin
        data_a_q <= i_data;
        exp_a_q  <= i_exp;
        left_a_q <= i_left;
        cnt_a_q  <= cnt_a_d;
      end
    end
  end

  assign exp_ext = {exp_a_q[EXP_W-1], exp_a_q};
  assign cnt_ext = XW'(cnt_a_q);

  // Shift and exponent adjustment; exponent math carries one guard bit for range detection.
  always_comb begin
    data_b_d   = '0;
    exp_x      = exp_ext;
    sticky_b_d = 1'b0;
    zero_b_d   = ~|data_a_q;
    if (left_a_q) begin
      data_b_d = data_a_q << cnt_a_q;
      if (!zero_b_d) begin
        exp_x = exp_ext - cnt_ext;
      end
    end else begin
      data_b_d = data_a_q >> cnt_a_q;
      exp_x    = exp_ext + cnt_ext;
`ifdef NORM_STICKY_EN
      sticky_b_d = |(data_a_q & ~({WIDTH{1'b1}} << cnt_a_q));
`endif
    end
    ovf_b_d = exp_x[XW-1] ^ exp_x[XW-2];
  end

  // Stage B: output register, held while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vb_q       <= 1'b0;
      data_b_q   <= '0;
      exp_b_q    <= '0;
      cnt_b_q    <= '0;
      zero_b_q   <= 1'b0;
      sticky_b_q <= 1'b0;
      ovf_b_q    <= 1'b0;
    end else if (adv_b) begin
      vb_q <= va_q;
      if (va_q) begin
        data_b_q   <= data_b_d;
        exp_b_q    <= exp_x[EXP_W-1:0];
        cnt_b_q    <= cnt_a_q;
        zero_b_q   <= zero_b_d;
        sticky_b_q <= sticky_b_d;
        ovf_b_q    <= ovf_b_d;
      end
    end
  end

  assign o_data    = data_b_q;
  assign o_exp     = exp_b_q;
  assign o_count   = cnt_b_q;
  assign o_zero    = zero_b_q;
  assign o_sticky  = sticky_b_q;
  assign o_exp_ovf = ovf_b_q;

endmodule
